// File: rtl/adder_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed adder scheduler.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned slices_f(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_sched_rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from a full-adder chain.
module rca_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             carryout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign carryout = w_c[CHUNK];

endmodule

// File: rtl/adder_share_sched.sv
// Round-robin shared serial adder: one CHUNK-bit slice reused across NREQ requesters.
// Optional signed-overflow output enabled by defining ADDER_SCHED_OVF_EN.
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [id_w(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
`ifdef ADDER_SCHED_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  localparam int unsigned SLICES = slices_f(WIDTH, CHUNK);
  localparam int unsigned IDW    = id_w(NREQ);
  localparam int unsigned IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("adder_share_sched: WIDTH must be a multiple of CHUNK");
  end

  state_t            r_state;
  state_t            w_state_nx;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic [IDW-1:0]    w_gnt;
  logic              w_found;
  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_sl_a;
  logic [CHUNK-1:0]  w_sl_b;
  logic [CHUNK-1:0]  w_sl_sum;
  logic              w_sl_co;

  // Rotating search: first valid requester after the last one served.
  always_comb begin : p_arb
    int unsigned cand;
    w_found = 1'b0;
    w_gnt   = '0;
    cand    = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(r_ptr) + off) % NREQ;
      if (!w_found && req_valid[IDW'(cand)]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(cand);
      end
    end
  end

  assign w_last = (r_idx == IDXW'(SLICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    req_ready  = '0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_accept         = 1'b1;
          w_state_nx       = CALC;
        end
      end
      CALC:    if (w_last) w_state_nx = DONE;
      DONE:    if (rsp_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_sl_a = r_a[r_idx*CHUNK +: CHUNK];
  assign w_sl_b = r_b[r_idx*CHUNK +: CHUNK];

  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (w_sl_a),
    .b        (w_sl_b),
    .cin      (r_carry),
    .sum      (w_sl_sum),
    .carryout (w_sl_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= req_a[w_gnt*WIDTH +: WIDTH];
      r_b     <= req_b[w_gnt*WIDTH +: WIDTH];
      r_carry <= req_cin[w_gnt];
      r_id    <= w_gnt;
      r_ptr   <= w_gnt;
      r_idx   <= '0;
    end else if (r_state == CALC) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= w_sl_sum;
      r_carry <= w_sl_co;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) r_cout <= w_sl_co;
    end
  end

`ifdef ADDER_SCHED_OVF_EN
  logic r_ovf;
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (r_state == CALC && w_last)
      r_ovf <= (w_sl_sum[CHUNK-1] ^ w_sl_a[CHUNK-1] ^ w_sl_b[CHUNK-1]) ^ w_sl_co;
  end
  assign rsp_ovf = r_ovf;
`endif

  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed + randomized bench for adder_share_sched against an arithmetic reference model.
module tb_adder_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int SL    = WIDTH / CHUNK;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;
`ifdef ADDER_SCHED_OVF_EN
  logic                  rsp_ovf;
`endif

  adder_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
`ifdef ADDER_SCHED_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: operand copies per requester and last-served pointer.
  logic [WIDTH-1:0] m_a   [NREQ];
  logic [WIDTH-1:0] m_b   [NREQ];
  logic             m_cin [NREQ];
  int               m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int j, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    m_a[j] = a;
    m_b[j] = b;
    m_cin[j] = cin;
    req_a[j*WIDTH +: WIDTH] = a;
    req_b[j*WIDTH +: WIDTH] = b;
    req_cin[j] = cin;
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int off = 1; off <= NREQ; off++) begin
      int j;
      j = (m_ptr + off) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One full operation: accept, serial calc, optional backpressure, handshake.
  task automatic run_op(input int hold, input bit drop);
    int              g;
    int              eg;
    int              waited;
    logic [WIDTH:0]  full;
    logic            eovf;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (req_ready == '0) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    check("ready_onehot", 32'($countones(req_ready)), 32'd1);
    g = 0;
    for (int j = 0; j < NREQ; j++) if (req_ready[j]) g = j;
    eg = exp_grant(req_valid);
    check("grant", 32'(g), 32'(eg));
    if (eg < 0) return;
    full = {1'b0, m_a[eg]} + {1'b0, m_b[eg]} + {{WIDTH{1'b0}}, m_cin[eg]};
    eovf = (m_a[eg][WIDTH-1] == m_b[eg][WIDTH-1]) && (full[WIDTH-1] != m_a[eg][WIDTH-1]);
    @(posedge clk); #1;
    m_ptr = eg;
    if (drop) req_valid[eg] = 1'b0;
    else set_op(eg, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    if (hold > 0) rsp_ready = 1'b0;
    check("busy_calc", 32'(busy), 32'd1);
    check("ready_calc", 32'(req_ready), 32'd0);
    for (int c = 1; c <= SL; c++) begin
      @(posedge clk); #1;
      if (c < SL) check("early_valid", 32'(rsp_valid), 32'd0);
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_sum", 32'(rsp_sum), 32'(full[WIDTH-1:0]));
    check("rsp_cout", 32'(rsp_cout), 32'(full[WIDTH]));
    check("rsp_id", 32'(rsp_id), 32'(eg));
    check("ready_done", 32'(req_ready), 32'd0);
`ifdef ADDER_SCHED_OVF_EN
    check("rsp_ovf", 32'(rsp_ovf), 32'(eovf));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_sum", 32'(rsp_sum), 32'(full[WIDTH-1:0]));
      check("hold_id", 32'(rsp_id), 32'(eg));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] add;
    logic [NREQ-1:0] fresh;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    m_ptr     = NREQ - 1;
    for (int j = 0; j < NREQ; j++) set_op(j, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_cout", 32'(rsp_cout), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Overflow through every slice, then carry-in path.
    set_op(0, 16'hFFFF, 16'h0001, 1'b0);
    req_valid = 4'b0001;
    run_op(0, 1'b1);
    set_op(0, 16'h1234, 16'h4321, 1'b1);
    req_valid = 4'b0001;
    run_op(0, 1'b1);

    // All requesters competing.
    for (int j = 0; j < NREQ; j++) set_op(j, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    req_valid = '1;
    for (int k = 0; k < 5; k++) run_op(0, 1'b0);

    run_op(10, 1'b0);

    for (int j = 0; j < NREQ; j++) set_op(j, 16'h0000, 16'h0000, 1'b1);
    run_op(0, 1'b0);
    for (int j = 0; j < NREQ; j++) set_op(j, 16'hFFFF, 16'hFFFF, 1'b1);
    run_op(0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      add   = 4'($urandom_range(1, 15));
      fresh = add & ~req_valid;
      for (int j = 0; j < NREQ; j++)
        if (fresh[j]) set_op(j, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      req_valid = req_valid | add;
      run_op($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Abort in the middle of the serial calculation.
    req_valid = 4'b0001;
    set_op(0, 16'hFFFF, 16'h0000, 1'b0);
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_sum", 32'(rsp_sum), 32'd0);
    req_valid = '0;
    m_ptr = NREQ - 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < NREQ; j++) set_op(j, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    req_valid = '1;
    run_op(0, 1'b1);
    check("post_reset_ptr", 32'(m_ptr), 32'd0);

`ifdef ADDER_SCHED_OVF_EN
    for (int j = 0; j < NREQ; j++) set_op(j, 16'h7FFF, 16'h0001, 1'b0);
    run_op(0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Time-multiplexes one narrow CHUNK-bit ripple-carry slice across NREQ requesters.
- Performs full WIDTH-bit additions serially, least-significant slice first, with the carry held in a register between slices.
- Round-robin arbiter grants one requester per operation; the result returns on a single response channel tagged with the requester id.
- Sits between client blocks and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and sum width; must be a multiple of CHUNK.
- CHUNK, 4, slice width added per cycle; SLICES = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  final carry-out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low (rst_n), and deasserts synchronously with clk.
- Reset values:
  - state = IDLE; busy = 0; req_ready = 0; rsp_valid = 0.
  - rsp_id = 0; rsp_sum = 0; rsp_cout = 0.
  - carry register = 0; slice index = 0.
  - rr pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Arbiter searches req_valid starting at (ptr+1) mod NREQ, wrapping; first set bit wins.
  - req_ready is combinational, one-hot on the winner, zero when no requests.
  - On the req_valid[g] && req_ready[g] edge:
    - latch A, B and cin[g] into the carry register;
    - rsp_id <= g; ptr <= g; idx <= 0; go to CALC.
- CALC:
  - Each cycle, slice idx of A and B plus the carry register feed the slice adder.
  - At the edge:
    - the slice sum is written to rsp_sum[idx*CHUNK +: CHUNK];
    - the carry register takes the slice carry-out;
    - idx increments.
  - After slice SLICES-1: rsp_cout <= slice carry; go to DONE.
  - req_ready = 0 throughout.
- DONE:
  - rsp_valid = 1; rsp_id, rsp_sum and rsp_cout stay stable until rsp_valid && rsp_ready.
  - On that edge go to IDLE.
  - Arbitration resumes the next cycle; there is no accept in the same cycle as the response handshake.
- Latency:
  - Accept at edge k gives rsp_valid high after edge k+SLICES.
  - Minimum spacing between accepts is SLICES+2 cycles.
- Boundary conditions:
  - Wrap: ptr = NREQ-1 with request 0 pending grants 0.
  - Only the granted requester may drop valid. Requesters not granted must hold valid and operands; the block samples only at accept.
  - Arithmetic is modulo 2^WIDTH; the carry out of bit WIDTH-1 is rsp_cout.
  - rsp_ready may be high before rsp_valid; it has no effect outside DONE.
  - Reset asserted mid-CALC or mid-DONE aborts immediately: the operation is lost, all outputs return to reset values, and the pending requester gets no response.
  - CHUNK == WIDTH is legal (SLICES = 1, single CALC cycle).

Optional Feature:
- Macro: ADDER_SCHED_OVF_EN.
- Defined:
  - adds output rsp_ovf (1 bit, reset 0), two's-complement signed overflow;
  - rsp_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured on the final CALC slice;
  - held stable with the rest of the response in DONE.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package adder_sched_pkg holds:
  - state enum type (IDLE, CALC, DONE);
  - localparam-style helper function for SLICES;
  - id width function ($clog2 with min 1).
- One sub-module, rca_slice:
  - combinational CHUNK-bit ripple-carry adder with ports a, b, cin, sum, carryout;
  - built from a full-adder chain and instantiated once.
- Parameter check: WIDTH % CHUNK != 0 fails elaboration via $error.

Test Plan:
- Single add with defaults: req0 valid, A=16'hFFFF, B=16'h0001, cin=0 -> accept, then 4 cycles later rsp_valid=1, rsp_sum=16'h0000, rsp_cout=1, rsp_id=0.
- Carry-in path: A=16'h1234, B=16'h4321, cin=1 -> rsp_sum=16'h5556, rsp_cout=0.
- Round robin fairness: all 4 requesters valid continuously -> grant order 0,1,2,3,0; req_ready never has more than one bit set.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable; no req_ready asserted until one cycle after the response handshake.
- Reset mid-CALC: assert rst_n=0 after 2 slices -> busy, rsp_valid and rsp_sum go to 0 immediately; after release, requester 0 is granted first.
- With ADDER_SCHED_OVF_EN defined: A=16'h7FFF, B=16'h0001 -> rsp_sum=16'h8000, rsp_ovf=1, rsp_cout=0.
